// File: rtl/e1b_code_loader.sv
// e1b_code_loader: sequences a full E1B code-table load from CPU strobes into the memory write port.
// Optional running checksum enabled by defining E1B_LOADER_CKSUM_EN.
module e1b_code_loader #(
    parameter int DEPTH  = 4092,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    input  logic              cmd_wr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              code_ready,
    output logic              busy,
    output logic [ADDR_W:0]   words,
    output logic              err_overrun,
    output logic              err_stray,
    output logic [DATA_W-1:0] cksum
);
    typedef enum logic [1:0] {IDLE, LOAD, READY, ERR} state_t;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    state_t state_q, state_d;
    logic start, wr, wr_acc;
    logic mem_wr_q, mem_wr_d, code_ready_q, code_ready_d, busy_q, busy_d;
    logic err_overrun_q, err_overrun_d, err_stray_q, err_stray_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0] words_q, words_d;
    // a write losing to start/abort is dropped entirely, never counted as stray
    assign start  = cmd_start & ~cmd_abort;
    assign wr     = cmd_wr & ~cmd_start & ~cmd_abort;
    assign wr_acc = wr & (state_q == LOAD);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (cmd_abort)                           state_d = IDLE;
        else if (cmd_start)                      state_d = LOAD;
        else if (wr_acc && words_q == LAST)      state_d = READY;
        else if (wr && state_q == READY)         state_d = ERR;
    end
    always_comb begin
        mem_wr_d      = wr_acc;
        mem_waddr_d   = wr_acc ? words_q[ADDR_W-1:0] : mem_waddr_q;
        mem_wdata_d   = wr_acc ? cmd_data : mem_wdata_q;
        words_d       = start ? '0 : wr_acc ? words_q + 1'b1 : words_q;
        err_overrun_d = ~start & (err_overrun_q | (wr & (state_q == READY)));
        err_stray_d   = ~start & (err_stray_q | (wr & (state_q == IDLE)));
        busy_d        = state_d == LOAD;
        // ready only once the final write has been on the port for a cycle
        code_ready_d  = (state_d == READY) & (state_q == READY);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr_q      <= 1'b0;
            mem_waddr_q   <= '0;
            mem_wdata_q   <= '0;
            words_q       <= '0;
            err_overrun_q <= 1'b0;
            err_stray_q   <= 1'b0;
            busy_q        <= 1'b0;
            code_ready_q  <= 1'b0;
        end else begin
            mem_wr_q      <= mem_wr_d;
            mem_waddr_q   <= mem_waddr_d;
            mem_wdata_q   <= mem_wdata_d;
            words_q       <= words_d;
            err_overrun_q <= err_overrun_d;
            err_stray_q   <= err_stray_d;
            busy_q        <= busy_d;
            code_ready_q  <= code_ready_d;
        end
    end
`ifdef E1B_LOADER_CKSUM_EN
    logic [DATA_W-1:0] cksum_q, cksum_d;
    always_comb begin
        cksum_d = start ? '0 : wr_acc ? {cksum_q[DATA_W-2:0], cksum_q[DATA_W-1]} ^ cmd_data : cksum_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cksum_q <= '0;
        else     cksum_q <= cksum_d;
    end
    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif
    assign mem_wr      = mem_wr_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_wdata   = mem_wdata_q;
    assign words       = words_q;
    assign err_overrun = err_overrun_q;
    assign err_stray   = err_stray_q;
    assign busy        = busy_q;
    assign code_ready  = code_ready_q;
endmodule

// File: tb/tb_e1b_code_loader.sv
// tb_e1b_code_loader: vector table, directed load scenarios and random commands vs. a queue-based model.
module tb_e1b_code_loader;
    localparam int DEPTH = 4092;
    logic clk = 1'b0, rst = 1'b1;
    logic cmd_start = 0, cmd_abort = 0, cmd_wr = 0;
    logic [11:0] cmd_data = '0;
    logic mem_wr, code_ready, busy, err_overrun, err_stray;
    logic [11:0] mem_waddr, mem_wdata, cksum;
    logic [12:0] words;
    int n_cmp = 0, n_bad = 0;

    e1b_code_loader dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cmd_wr(cmd_wr), .cmd_data(cmd_data), .mem_wr(mem_wr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .code_ready(code_ready), .busy(busy), .words(words),
        .err_overrun(err_overrun), .err_stray(err_stray), .cksum(cksum)
    );

    always #5 clk = ~clk;

    // behavioural model: the committed table is a queue, mode is the protocol phase
    int m_mode;  // 0 idle, 1 loading, 2 ready, 3 error
    logic [11:0] loaded[$];
    logic m_wr, m_rdy, m_ovr, m_stray;
    int m_addr;
    logic [11:0] m_data;

    function automatic logic [11:0] fold();
        logic [11:0] c;
        c = '0;
        foreach (loaded[i]) c = {c[10:0], c[11]} ^ loaded[i];
        return c;
    endfunction

    function automatic logic [11:0] exp_ck();
`ifdef E1B_LOADER_CKSUM_EN
        return fold();
`else
        return 12'h000;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; loaded.delete(); m_wr = 0; m_rdy = 0; m_ovr = 0; m_stray = 0;
        m_addr = 0; m_data = '0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic w, input logic [11:0] d);
        int prev;
        prev = m_mode;
        m_wr = 0;
        if (a) m_mode = 0;
        else if (s) begin
            m_mode = 1; loaded.delete(); m_ovr = 0; m_stray = 0;
        end else if (w) begin
            if (m_mode == 0) m_stray = 1;
            else if (m_mode == 1) begin
                m_wr = 1; m_addr = loaded.size(); m_data = d; loaded.push_back(d);
                if (loaded.size() == DEPTH) m_mode = 2;
            end else if (m_mode == 2) begin
                m_ovr = 1; m_mode = 3;
            end
        end
        m_rdy = (prev == 2) && (m_mode == 2);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("mem_wr", 32'(mem_wr), 32'(m_wr));
        chk("mem_waddr", 32'(mem_waddr), 32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_data));
        chk("words", 32'(words), 32'(loaded.size()));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("code_ready", 32'(code_ready), 32'(m_rdy));
        chk("err_overrun", 32'(err_overrun), 32'(m_ovr));
        chk("err_stray", 32'(err_stray), 32'(m_stray));
        chk("cksum", 32'(cksum), 32'(exp_ck()));
    endtask

    // inputs change at negedge; outputs are compared at the following negedge
    task automatic drive(input logic s, input logic a, input logic w, input logic [11:0] d);
        cmd_start = s; cmd_abort = a; cmd_wr = w; cmd_data = d;
        @(posedge clk);
        model_step(s, a, w, d);
        @(negedge clk);
        cmd_start = 0; cmd_abort = 0; cmd_wr = 0;
    endtask

    task automatic step_chk(input logic s, input logic a, input logic w, input logic [11:0] d);
        drive(s, a, w, d);
        check_model();
    endtask

    typedef struct packed {
        logic s, a, w;
        logic [11:0] d;
        logic e_wr;
        logic [11:0] e_addr, e_data;
        logic [12:0] e_words;
        logic e_busy, e_rdy, e_ovr, e_stray;
        logic [11:0] e_ck;
    } vec_t;
    vec_t tv[12];

    initial begin
        tv[0]  = '{1'b0,1'b0,1'b1,12'h005, 1'b0,12'h000,12'h000,13'd0, 1'b0,1'b0,1'b0,1'b1,12'h000};
        tv[1]  = '{1'b1,1'b0,1'b0,12'h000, 1'b0,12'h000,12'h000,13'd0, 1'b1,1'b0,1'b0,1'b0,12'h000};
        tv[2]  = '{1'b0,1'b0,1'b1,12'h111, 1'b1,12'h000,12'h111,13'd1, 1'b1,1'b0,1'b0,1'b0,12'h111};
        tv[3]  = '{1'b0,1'b0,1'b1,12'h222, 1'b1,12'h001,12'h222,13'd2, 1'b1,1'b0,1'b0,1'b0,12'h000};
        tv[4]  = '{1'b0,1'b0,1'b0,12'h000, 1'b0,12'h001,12'h222,13'd2, 1'b1,1'b0,1'b0,1'b0,12'h000};
        tv[5]  = '{1'b1,1'b0,1'b1,12'h0F0, 1'b0,12'h001,12'h222,13'd0, 1'b1,1'b0,1'b0,1'b0,12'h000};
        tv[6]  = '{1'b0,1'b0,1'b1,12'h333, 1'b1,12'h000,12'h333,13'd1, 1'b1,1'b0,1'b0,1'b0,12'h333};
        tv[7]  = '{1'b1,1'b1,1'b0,12'h000, 1'b0,12'h000,12'h333,13'd1, 1'b0,1'b0,1'b0,1'b0,12'h333};
        tv[8]  = '{1'b0,1'b0,1'b1,12'h444, 1'b0,12'h000,12'h333,13'd1, 1'b0,1'b0,1'b0,1'b1,12'h333};
        tv[9]  = '{1'b0,1'b1,1'b0,12'h000, 1'b0,12'h000,12'h333,13'd1, 1'b0,1'b0,1'b0,1'b1,12'h333};
        tv[10] = '{1'b1,1'b0,1'b0,12'h000, 1'b0,12'h000,12'h333,13'd0, 1'b1,1'b0,1'b0,1'b0,12'h000};
        tv[11] = '{1'b0,1'b1,1'b1,12'h555, 1'b0,12'h000,12'h333,13'd0, 1'b0,1'b0,1'b0,1'b0,12'h000};

        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_model();

        for (int i = 0; i < 12; i++) begin
            logic [11:0] ck;
`ifdef E1B_LOADER_CKSUM_EN
            ck = tv[i].e_ck;
`else
            ck = 12'h000;
`endif
            drive(tv[i].s, tv[i].a, tv[i].w, tv[i].d);
            chk($sformatf("tv%0d_mem_wr", i), 32'(mem_wr), 32'(tv[i].e_wr));
            chk($sformatf("tv%0d_addr", i), 32'(mem_waddr), 32'(tv[i].e_addr));
            chk($sformatf("tv%0d_data", i), 32'(mem_wdata), 32'(tv[i].e_data));
            chk($sformatf("tv%0d_words", i), 32'(words), 32'(tv[i].e_words));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
            chk($sformatf("tv%0d_ready", i), 32'(code_ready), 32'(tv[i].e_rdy));
            chk($sformatf("tv%0d_ovr", i), 32'(err_overrun), 32'(tv[i].e_ovr));
            chk($sformatf("tv%0d_stray", i), 32'(err_stray), 32'(tv[i].e_stray));
            chk($sformatf("tv%0d_cksum", i), 32'(cksum), 32'(ck));
        end

        // full load with data = address
        step_chk(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step_chk(0, 0, 1, 12'(i));
        chk("last_addr", 32'(mem_waddr), DEPTH - 1);
        chk("ready_not_yet", 32'(code_ready), 0);
        step_chk(0, 0, 0, 0);
        chk("ready_after_load", 32'(code_ready), 1);
        chk("words_full", 32'(words), DEPTH);

        // overrun
        step_chk(0, 0, 1, 12'hABC);
        chk("ovr_no_write", 32'(mem_wr), 0);
        chk("ovr_flag", 32'(err_overrun), 1);
        chk("ovr_not_ready", 32'(code_ready), 0);
        step_chk(0, 0, 1, 12'h123);
        step_chk(1, 0, 0, 0);
        chk("ovr_cleared", 32'(err_overrun), 0);

        // restart mid-load
        for (int i = 0; i < 100; i++) step_chk(0, 0, 1, 12'($urandom));
        step_chk(1, 0, 0, 0);
        chk("restart_words", 32'(words), 0);
        step_chk(0, 0, 1, 12'h777);
        chk("restart_addr0", 32'(mem_waddr), 0);
        for (int i = 1; i < DEPTH; i++) step_chk(0, 0, 1, 12'($urandom));
        step_chk(0, 0, 0, 0);
        chk("restart_ready", 32'(code_ready), 1);

        // asynchronous reset mid-load at words = 2000 with a write in flight
        step_chk(1, 0, 0, 0);
        for (int i = 0; i < 2000; i++) step_chk(0, 0, 1, 12'($urandom));
        cmd_wr = 1; cmd_data = 12'hFFF;
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_outputs", {mem_wr, mem_waddr, mem_wdata, code_ready, busy, words, err_overrun, err_stray, cksum}, 0);
        chk("arst_words", 32'(words), 0);
        model_reset();
        @(negedge clk);
        cmd_wr = 0;
        rst = 0;
        step_chk(0, 0, 1, 12'h0AA);
        chk("arst_stray", 32'(err_stray), 1);

        // checksum load of constant 0x001
        step_chk(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step_chk(0, 0, 1, 12'h001);
        step_chk(0, 0, 0, 0);
        chk("cksum_final", 32'(cksum), 32'(exp_ck()));

        // random commands from READY onward
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            step_chk(r < 6, r >= 6 && r < 10, $urandom_range(0, 3) != 0, 12'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/e1b_code_loader.md
# e1b_code_loader

Host-facing load controller for the shared E1B code memory. Sequences a full code-table load (one 12-bit word per chip index, one bit per channel) from CPU command strobes into the memory write port. Generates write address and strobe, counts words, and flags protocol errors. Holds `code_ready` low until a complete, clean table is committed, so the GPS channels never run on a partial table.

## Interface
Parameters:
- `DEPTH`, 4092: words per full load (E1B code length in chips).
- `ADDR_W`, 12: memory address width; `DEPTH` ≤ 2^`ADDR_W`.
- `DATA_W`, 12: word width, one bit per GPS channel.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_start`  in  1  one-cycle pulse: begin a new load and clear the error flags.
- `cmd_abort`  in  1  one-cycle pulse: abandon the load and return to IDLE.
- `cmd_wr`  in  1  one-cycle pulse: `cmd_data` is the next code word.
- `cmd_data`  in  `DATA_W`  code word; sampled only when `cmd_wr` is high.
- `mem_wr`  out  1  memory write enable.
- `mem_waddr`  out  `ADDR_W`  memory write address.
- `mem_wdata`  out  `DATA_W`  memory write data.
- `code_ready`  out  1  table complete and valid; gates channel use.
- `busy`  out  1  high in LOAD.
- `words`  out  `ADDR_W`+1  words committed in the current load.
- `err_overrun`  out  1  sticky flag: a write arrived after the table was full.
- `err_stray`  out  1  sticky flag: a write arrived in IDLE.
- `cksum`  out  `DATA_W`  running checksum of the loaded words (see Configuration).

## Operation
- States: IDLE, LOAD, READY, ERR. Reset enters IDLE.
- All outputs are registered. Reset values of all outputs are 0.
- Command priority, when pulses coincide: `cmd_abort` > `cmd_start` > `cmd_wr`. A `cmd_wr` that loses to `cmd_start` or `cmd_abort` is discarded and does not count as stray.
- IDLE:
  - `cmd_start` → LOAD; clears `words`, the error flags and `cksum`.
  - `cmd_wr` → sets `err_stray`, no write, stays in IDLE.
- LOAD:
  - `cmd_wr` → write `cmd_data` at address `words`, then increment `words`.
  - After write number `DEPTH` → READY.
  - `cmd_start` → restart: `words`=0, state stays LOAD.
  - `cmd_abort` → IDLE; `words` is held for debug.
- READY:
  - `code_ready`=1.
  - `cmd_wr` → ERR with `err_overrun` set; no write is issued.
  - `cmd_start` → LOAD.
  - `cmd_abort` → IDLE.
- ERR:
  - `code_ready`=0; `cmd_wr` ignored.
  - Exits only via `cmd_start` (→ LOAD) or `cmd_abort` (→ IDLE, flags retained).
- `code_ready` is 1 only in READY.
- `mem_waddr` never reaches or exceeds `DEPTH`; no wrap-around write is possible.
- Back-to-back `cmd_wr` on every cycle is supported. No backpressure.

## Timing
- `cmd_wr` at cycle N → `mem_wr`=1 at N+1, carrying `mem_waddr`=old `words` and `mem_wdata`=`cmd_data`(N). `words` increments at N+1.
- `mem_wr` is a one-cycle pulse per accepted word. `mem_waddr`/`mem_wdata` hold their last values when `mem_wr`=0.
- Final word: `cmd_wr` at N → `mem_wr` at N+1 (address `DEPTH`-1) → `code_ready`=1 at N+2, once the write is committed.
- Leaving READY because of `cmd_start`, `cmd_abort` or `cmd_wr` at cycle M → `code_ready`=0 at M+1.
- `busy` follows the state register: high at cycle N+1 after `cmd_start` at N.
- Error flags set at N+1 after the offending `cmd_wr` at N.
- `rst` asserted mid-load: all outputs drop to 0 asynchronously. A write pulse in flight is killed. Host must reload.

## Configuration
- `E1B_LOADER_CKSUM_EN` defined:
  - On each accepted write, `cksum` ← rotate-left-1(`cksum`) XOR `cmd_data`, updated at the same edge as `mem_wr`.
  - `cmd_start` clears `cksum`.
  - The host compares `cksum` against a precomputed value.
- Not defined: `cksum` is tied to 0 and the checksum logic is absent. The port remains.

## Test plan
- Full load: `cmd_start`, then 4092 back-to-back `cmd_wr` with data = address[11:0]. Expect 4092 `mem_wr` pulses at addresses 0..4091 with matching data, `code_ready`=1 two cycles after the last `cmd_wr`, `words`=4092, no errors.
- Overrun: after a full load, one extra `cmd_wr` of 0xABC. Expect no `mem_wr`, `err_overrun`=1, `code_ready`=0 next cycle, state ERR; a following `cmd_start` clears `err_overrun`.
- Stray and priority: `cmd_wr` in IDLE sets `err_stray`. In LOAD, `cmd_start` and `cmd_wr` in the same cycle → no write, `words`=0. `cmd_abort` together with `cmd_start` → IDLE.
- Restart mid-load: write 100 words, then `cmd_start`, then 4092 words. Expect addresses restart at 0 and READY after 4092 more writes.
- Async reset: assert `rst` between two clock edges during LOAD at `words`=2000. Expect all outputs 0 immediately; after release, state IDLE and `cmd_wr` flagged as stray.
- Checksum (macro on): load 4092 words of 0x001. Expect `cksum` equal to the reference-model fold (0x001 rotated and XORed 4092 times). With the macro off, `cksum`=0 throughout.
